// File: rtl/reg_file_master.sv
// reg_file_master: sequences single/burst read and write commands onto the
// register file port and returns one response per read beat or write burst.
module reg_file_master #(
    parameter int ADDR_Width = 4,
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_DEPTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Cmd_Valid,
    output logic                  Cmd_Ready,
    input  logic                  Cmd_Op,
    input  logic [ADDR_Width-1:0] Cmd_Addr,
    input  logic [ADDR_Width-1:0] Cmd_Len,
    input  logic                  Wd_Valid,
    output logic                  Wd_Ready,
    input  logic [MEM_WIDTH-1:0]  Wd_Data,
    output logic                  Rsp_Valid,
    input  logic                  Rsp_Ready,
    output logic [MEM_WIDTH-1:0]  Rsp_Data,
    output logic                  Rsp_Last,
    output logic                  Rsp_Err,
    output logic [MEM_WIDTH-1:0]  WrData,
    output logic [ADDR_Width-1:0] Address,
    output logic                  WrEn,
    output logic                  RdEn,
    input  logic [MEM_WIDTH-1:0]  RdData
);
    typedef enum logic [2:0] {IDLE, WR_DATA, WR_COMMIT, WR_RESP, RD_WAIT, RD_CAP, RD_RESP, ERR_RESP} state_e;
    state_e                state_q, state_d;
    logic [ADDR_Width-1:0] cnt_q, cnt_d, cur_q, cur_d, addr_q, addr_d;
    logic [MEM_WIDTH-1:0]  wr_data_q, wr_data_d, rsp_data_q, rsp_data_d;
    logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d, rsp_err_q, rsp_err_d;
    logic                  accept, illegal, wd_hs, rsp_hs, last;
    logic [ADDR_Width-1:0] nxt_addr;

    assign Cmd_Ready = (state_q == IDLE);
    assign Wd_Ready  = (state_q == WR_DATA);
    assign accept    = Cmd_Valid && Cmd_Ready;
    assign wd_hs     = Wd_Valid && Wd_Ready;
    assign rsp_hs    = rsp_valid_q && Rsp_Ready;
    assign illegal   = int'(Cmd_Addr) >= MEM_DEPTH || int'(Cmd_Len) >= MEM_DEPTH;
    assign last      = (cnt_q == '0);
    assign nxt_addr  = (int'(cur_q) == MEM_DEPTH - 1) ? '0 : cur_q + 1'b1;

    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign Address   = addr_q;
    assign WrData    = wr_data_q;
    assign Rsp_Valid = rsp_valid_q;
    assign Rsp_Data  = rsp_data_q;
    assign Rsp_Last  = rsp_last_q;
    assign Rsp_Err   = rsp_err_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            rsp_data_q  <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            rsp_data_q  <= rsp_data_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:              if (accept) state_d = illegal ? ERR_RESP : (Cmd_Op ? RD_WAIT : WR_DATA);
            WR_DATA:           if (wd_hs) state_d = WR_COMMIT;
            WR_COMMIT:         state_d = last ? WR_RESP : WR_DATA;
            RD_WAIT:           state_d = RD_CAP;
            RD_CAP:            state_d = RD_RESP;
            RD_RESP:           if (rsp_hs) state_d = last ? IDLE : RD_WAIT;
            WR_RESP, ERR_RESP: if (rsp_hs) state_d = IDLE;
            default:           state_d = IDLE;
        endcase
    end

    // Enables default low so every WrEn/RdEn is a single-cycle pulse.
    always_comb begin
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        rsp_data_d  = rsp_data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (accept) begin
                cnt_d = Cmd_Len;
                cur_d = Cmd_Addr;
                if (illegal) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_data_d  = '0;
                end else if (Cmd_Op) begin
                    rd_en_d = 1'b1;
                    addr_d  = Cmd_Addr;
                end
            end
            WR_DATA: if (wd_hs) begin
                wr_en_d   = 1'b1;
                wr_data_d = Wd_Data;
                addr_d    = cur_q;
            end
            WR_COMMIT: if (last) begin
                rsp_valid_d = 1'b1;
                rsp_last_d  = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
                cur_d = nxt_addr;
            end
            RD_CAP: begin
                rsp_data_d  = RdData;
                rsp_valid_d = 1'b1;
                rsp_last_d  = last;
                rsp_err_d   = 1'b0;
            end
            RD_RESP: if (rsp_hs) begin
                rsp_valid_d = 1'b0;
                if (!last) begin
                    rd_en_d = 1'b1;
                    addr_d  = nxt_addr;
                    cur_d   = nxt_addr;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            WR_RESP, ERR_RESP: if (rsp_hs) begin
                rsp_valid_d = 1'b0;
                rsp_last_d  = 1'b0;
                rsp_err_d   = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_reg_file_master.sv
// tb_reg_file_master: table-driven command vectors plus hand sequences, with a
// register file model and scoreboard queues for responses, writes and reads.
module tb_reg_file_master;
    logic        CLK = 1'b0, RST = 1'b0;
    logic        Cmd_Valid = 1'b0, Cmd_Op = 1'b0, Wd_Valid = 1'b0, Rsp_Ready = 1'b1;
    logic [3:0]  Cmd_Addr = '0, Cmd_Len = '0;
    logic [15:0] Wd_Data = '0;
    logic        Cmd_Ready, Wd_Ready, Rsp_Valid, Rsp_Last, Rsp_Err, WrEn, RdEn;
    logic [15:0] Rsp_Data, WrData, RdData;
    logic [3:0]  Address;

    always #5 CLK = ~CLK;

    reg_file_master dut (
        .CLK(CLK), .RST(RST), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op),
        .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len), .Wd_Valid(Wd_Valid), .Wd_Ready(Wd_Ready),
        .Wd_Data(Wd_Data), .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Data(Rsp_Data),
        .Rsp_Last(Rsp_Last), .Rsp_Err(Rsp_Err), .WrData(WrData), .Address(Address),
        .WrEn(WrEn), .RdEn(RdEn), .RdData(RdData)
    );

    // Register file model: registered read data, valid the edge after RdEn.
    logic [15:0] rf [8];
    always @(posedge CLK) begin
        if (WrEn) rf[Address[2:0]] <= WrData;
        if (RdEn) RdData <= rf[Address[2:0]];
    end

    typedef struct packed {logic [15:0] data; logic last; logic err;} rsp_t;
    typedef struct packed {logic [3:0] addr; logic [15:0] data;} wr_t;
    typedef struct packed {logic op; logic [3:0] addr; logic [3:0] len; logic [3:0][15:0] d; logic err;} vec_t;

    rsp_t       rsp_q[$];
    wr_t        wr_q[$];
    logic [3:0] rd_q[$];
    rsp_t       r_e;
    wr_t        w_e;
    logic [3:0] a_e;
    int n_chk = 0, n_pass = 0, excl_bad = 0, wd_hs = 0;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (WrEn && RdEn) excl_bad++;
        if (Wd_Valid && Wd_Ready) wd_hs++;
        if (WrEn) begin
            if (wr_q.size() == 0) chk("wr_unexpected", WrEn, 0);
            else begin
                w_e = wr_q.pop_front();
                chk("wr_addr", Address, w_e.addr);
                chk("wr_data", WrData, w_e.data);
            end
        end
        if (RdEn) begin
            if (rd_q.size() == 0) chk("rd_unexpected", RdEn, 0);
            else begin
                a_e = rd_q.pop_front();
                chk("rd_addr", Address, a_e);
            end
        end
        if (Rsp_Valid && Rsp_Ready) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", Rsp_Valid, 0);
            else begin
                r_e = rsp_q.pop_front();
                chk("rsp_data", Rsp_Data, r_e.data);
                chk("rsp_last", Rsp_Last, r_e.last);
                chk("rsp_err", Rsp_Err, r_e.err);
            end
        end
    end

    function automatic vec_t mkv(input logic op, input logic [3:0] a, input logic [3:0] l,
                                 input logic [15:0] d0, d1, d2, d3, input logic err);
        return '{op: op, addr: a, len: l, d: {d3, d2, d1, d0}, err: err};
    endfunction

    task automatic send_cmd(input logic op, input logic [3:0] a, input logic [3:0] l);
        @(posedge CLK); #1;
        Cmd_Op = op; Cmd_Addr = a; Cmd_Len = l; Cmd_Valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (Cmd_Ready) break;
        end
        chk("cmd_accept", Cmd_Ready, 1);
        @(posedge CLK); #1;
        Cmd_Valid = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d);
        @(posedge CLK); #1;
        Wd_Valid = 1'b1; Wd_Data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (Wd_Ready) break;
        end
        chk("wd_accept", Wd_Ready, 1);
        @(posedge CLK); #1;
        Wd_Valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK); #1;
            if (rsp_q.size() == 0 && wr_q.size() == 0 && rd_q.size() == 0) break;
        end
        chk("drain", rsp_q.size() + wr_q.size() + rd_q.size(), 0);
        rsp_q.delete(); wr_q.delete(); rd_q.delete();
        @(negedge CLK);
        chk("back_to_idle", Cmd_Ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0]  = mkv(0, 2, 0, 13, 0, 0, 0, 0);
        vecs[1]  = mkv(1, 2, 0, 13, 0, 0, 0, 0);
        vecs[2]  = mkv(0, 6, 3, 8, 9, 10, 11, 0);
        vecs[3]  = mkv(1, 6, 3, 8, 9, 10, 11, 0);
        vecs[4]  = mkv(1, 0, 1, 10, 11, 0, 0, 0);
        vecs[5]  = mkv(1, 9, 0, 0, 0, 0, 0, 1);
        vecs[6]  = mkv(1, 0, 8, 0, 0, 0, 0, 1);
        vecs[7]  = mkv(0, 3, 8, 0, 0, 0, 0, 1);
        vecs[8]  = mkv(0, 7, 1, 100, 200, 0, 0, 0);
        vecs[9]  = mkv(1, 7, 1, 100, 200, 0, 0, 0);
        vecs[10] = mkv(1, 1, 0, 11, 0, 0, 0, 0);

        Cmd_Valid = 1'b1; Cmd_Op = 1'b1; Cmd_Addr = 4'd2;
        repeat (3) @(negedge CLK);
        chk("rst_wren", WrEn, 0);
        chk("rst_rden", RdEn, 0);
        chk("rst_address", Address, 0);
        chk("rst_wrdata", WrData, 0);
        chk("rst_rsp_valid", Rsp_Valid, 0);
        chk("rst_rsp_data", Rsp_Data, 0);
        chk("rst_rsp_last", Rsp_Last, 0);
        chk("rst_rsp_err", Rsp_Err, 0);
        @(posedge CLK); #1;
        Cmd_Valid = 1'b0; RST = 1'b1;
        @(negedge CLK);
        chk("rst_cmd_ready", Cmd_Ready, 1);
        chk("rst_rden_after", RdEn, 0);

        foreach (vecs[k]) begin
            v = vecs[k];
            if (v.err) rsp_q.push_back('{data: 16'd0, last: 1'b1, err: 1'b1});
            else if (!v.op) begin
                for (int i = 0; i <= int'(v.len); i++) wr_q.push_back('{addr: 4'((int'(v.addr) + i) % 8), data: v.d[i]});
                rsp_q.push_back('{data: 16'd0, last: 1'b1, err: 1'b0});
            end else begin
                for (int i = 0; i <= int'(v.len); i++) begin
                    rd_q.push_back(4'((int'(v.addr) + i) % 8));
                    rsp_q.push_back('{data: v.d[i], last: (i == int'(v.len)), err: 1'b0});
                end
            end
            send_cmd(v.op, v.addr, v.len);
            if (!v.err && !v.op) for (int i = 0; i <= int'(v.len); i++) send_beat(v.d[i]);
            drain();
        end

        // Read latency: RdEn for one cycle, response two cycles after accept.
        rd_q.push_back(4'd2);
        rsp_q.push_back('{data: 16'd13, last: 1'b1, err: 1'b0});
        send_cmd(1, 2, 0);
        @(negedge CLK);
        chk("lat_rden_e0", RdEn, 1);
        chk("lat_valid_e0", Rsp_Valid, 0);
        @(negedge CLK);
        chk("lat_rden_e1", RdEn, 0);
        chk("lat_valid_e1", Rsp_Valid, 0);
        @(negedge CLK);
        chk("lat_valid_e2", Rsp_Valid, 1);
        chk("lat_data_e2", Rsp_Data, 13);
        drain();

        // Backpressure: response held and no further RdEn while stalled.
        @(posedge CLK); #1;
        Rsp_Ready = 1'b0;
        rd_q.push_back(4'd6); rd_q.push_back(4'd7);
        rsp_q.push_back('{data: 16'd8, last: 1'b0, err: 1'b0});
        rsp_q.push_back('{data: 16'd100, last: 1'b1, err: 1'b0});
        send_cmd(1, 6, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (Rsp_Valid) break;
        end
        chk("bp_valid_rise", Rsp_Valid, 1);
        repeat (5) begin
            @(negedge CLK);
            chk("bp_valid_hold", Rsp_Valid, 1);
            chk("bp_data_hold", Rsp_Data, 8);
            chk("bp_last_hold", Rsp_Last, 0);
            chk("bp_no_rden", RdEn, 0);
        end
        @(posedge CLK); #1;
        Rsp_Ready = 1'b1;
        drain();

        // Illegal write with write data offered: nothing consumed, immediate error.
        @(posedge CLK); #1;
        Wd_Valid = 1'b1; Wd_Data = 16'hDEAD; wd_hs = 0;
        rsp_q.push_back('{data: 16'd0, last: 1'b1, err: 1'b1});
        send_cmd(0, 15, 0);
        chk("err_valid_lat", Rsp_Valid, 1);
        drain();
        chk("wd_ignored", wd_hs, 0);
        @(posedge CLK); #1;
        Wd_Valid = 1'b0;

        // Reset during the second beat of a write burst.
        wr_q.push_back('{addr: 4'd3, data: 16'd1});
        send_cmd(0, 3, 2);
        send_beat(16'd1);
        send_beat(16'd2);
        chk("midrst_wren_pre", WrEn, 1);
        #1 RST = 1'b0;
        #1;
        chk("midrst_wren", WrEn, 0);
        chk("midrst_idle", Cmd_Ready, 1);
        chk("midrst_address", Address, 0);
        chk("midrst_wrdata", WrData, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_ready_after", Cmd_Ready, 1);
        chk("midrst_wr_q", wr_q.size(), 0);
        chk("midrst_wd_ready", Wd_Ready, 0);

        chk("wren_rden_exclusive", excl_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
